// File: rtl/intra4x4_sad_decider.sv
// Intra 4x4 mode decision: snapshots the original block and eight directional predictions,
// accumulates per-mode SAD one row per cycle and reports the lowest-SAD mode.
module intra4x4_sad_decider #(
    parameter logic [7:0] MODE_MASK = 8'hFF,
    parameter int         SADW      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [127:0]      orig,
    input  logic [127:0]      vpred,
    input  logic [127:0]      hpred,
    input  logic [127:0]      vlpred,
    input  logic [127:0]      vrpred,
    input  logic [127:0]      hupred,
    input  logic [127:0]      hdpred,
    input  logic [127:0]      ddlpred,
    input  logic [127:0]      ddrpred,
    output logic              busy,
    output logic              done,
    output logic [3:0]        best_mode,
    output logic [SADW-1:0]   best_sad
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [127:0]      orig_q, orig_d;
    logic [127:0]      pred_q [8];
    logic [127:0]      pred_d [8];
    logic [127:0]      pred_in [8];
    logic [4:0]        idx_q, idx_d;
    logic              issued_q, issued_d;
    logic              p_vld_q, p_vld_d;
    logic [4:0]        p_idx_q, p_idx_d;
    logic [9:0]        row_sum_q, row_sum_d;
    logic [SADW-1:0]   acc_q, acc_d;
    logic [SADW-1:0]   min_sad_q, min_sad_d;
    logic [3:0]        min_mode_q, min_mode_d;
    logic [SADW-1:0]   best_sad_q, best_sad_d;
    logic [3:0]        best_mode_q, best_mode_d;

    logic [127:0]      cur_pred;
    logic [31:0]       orig_row;
    logic [31:0]       pred_row;
    logic [7:0]        absd [4];
    logic [9:0]        row_sum_c;
    logic [SADW-1:0]   slot_sad;

    // Slot order fixes the tie-break: earlier slot wins on equal SAD.
    assign pred_in[0] = vpred;
    assign pred_in[1] = hpred;
    assign pred_in[2] = ddlpred;
    assign pred_in[3] = ddrpred;
    assign pred_in[4] = vrpred;
    assign pred_in[5] = hdpred;
    assign pred_in[6] = vlpred;
    assign pred_in[7] = hupred;

    function automatic logic [3:0] slot_mode(input logic [2:0] s);
        logic [3:0] m;
        case (s)
            3'd0:    m = 4'd0;
            3'd1:    m = 4'd1;
            3'd2:    m = 4'd3;
            3'd3:    m = 4'd4;
            3'd4:    m = 4'd5;
            3'd5:    m = 4'd6;
            3'd6:    m = 4'd7;
            default: m = 4'd8;
        endcase
        return m;
    endfunction

    assign cur_pred = pred_q[idx_q[4:2]];
    assign orig_row = orig_q[idx_q[1:0]*32 +: 32];
    assign pred_row = cur_pred[idx_q[1:0]*32 +: 32];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_absd
            logic [7:0] a, b;
            assign a = orig_row[gi*8 +: 8];
            assign b = pred_row[gi*8 +: 8];
            assign absd[gi] = (a > b) ? (a - b) : (b - a);
        end
    endgenerate

    assign row_sum_c = 10'(absd[0]) + 10'(absd[1]) + 10'(absd[2]) + 10'(absd[3]);
    assign slot_sad  = acc_q + SADW'(row_sum_q);

    always_comb begin
        state_d     = state_q;
        orig_d      = orig_q;
        for (int i = 0; i < 8; i++) pred_d[i] = pred_q[i];
        idx_d       = idx_q;
        issued_d    = issued_q;
        p_vld_d     = p_vld_q;
        p_idx_d     = p_idx_q;
        row_sum_d   = row_sum_q;
        acc_d       = acc_q;
        min_sad_d   = min_sad_q;
        min_mode_d  = min_mode_q;
        best_sad_d  = best_sad_q;
        best_mode_d = best_mode_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    orig_d = orig;
                    for (int i = 0; i < 8; i++) pred_d[i] = pred_in[i];
                    idx_d      = '0;
                    issued_d   = 1'b0;
                    p_vld_d    = 1'b0;
                    acc_d      = '0;
                    min_sad_d  = '1;
                    min_mode_d = 4'hF;
                    state_d    = CALC;
                end
            end
            CALC: begin
                // Stage 1: row SAD of the current slot/row into a register.
                p_vld_d = 1'b0;
                if (!issued_q) begin
                    row_sum_d = row_sum_c;
                    p_idx_d   = idx_q;
                    p_vld_d   = 1'b1;
                    idx_d     = 5'(idx_q + 5'd1);
                    if (idx_q == 5'd31) issued_d = 1'b1;
                end
                // Stage 2: accumulate; at row 3 the slot SAD is final.
                if (p_vld_q) begin
                    if (p_idx_q[1:0] == 2'd3) begin
                        acc_d = '0;
                        if (MODE_MASK[p_idx_q[4:2]] && (slot_sad < min_sad_q)) begin
                            min_sad_d  = slot_sad;
                            min_mode_d = slot_mode(p_idx_q[4:2]);
                        end
                        if (p_idx_q == 5'd31) begin
                            best_sad_d  = min_sad_d;
                            best_mode_d = min_mode_d;
                            state_d     = DONE;
                        end
                    end else begin
                        acc_d = slot_sad;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            issued_q    <= 1'b0;
            p_vld_q     <= 1'b0;
            p_idx_q     <= '0;
            row_sum_q   <= '0;
            acc_q       <= '0;
            min_sad_q   <= '1;
            min_mode_q  <= 4'hF;
            best_sad_q  <= '1;
            best_mode_q <= 4'hF;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            issued_q    <= issued_d;
            p_vld_q     <= p_vld_d;
            p_idx_q     <= p_idx_d;
            row_sum_q   <= row_sum_d;
            acc_q       <= acc_d;
            min_sad_q   <= min_sad_d;
            min_mode_q  <= min_mode_d;
            best_sad_q  <= best_sad_d;
            best_mode_q <= best_mode_d;
        end
    end

    // Snapshot holds pure data; its contents are don't-care until the next start.
    always_ff @(posedge clk) begin
        orig_q <= orig_d;
        for (int i = 0; i < 8; i++) pred_q[i] <= pred_d[i];
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;

endmodule

// File: tb/tb_intra4x4_sad_decider.sv
// Directed bench for intra4x4_sad_decider: full-mask and zero-mask instances share stimulus.
module tb_intra4x4_sad_decider;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] orig, vpred, hpred, vlpred, vrpred, hupred, hdpred, ddlpred, ddrpred;
    logic         busy, done, busy_m, done_m;
    logic [3:0]   best_mode, best_mode_m;
    logic [11:0]  best_sad, best_sad_m;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    intra4x4_sad_decider #(.MODE_MASK(8'hFF), .SADW(12)) u_dut (
        .clk(clk), .reset(reset), .start(start), .orig(orig),
        .vpred(vpred), .hpred(hpred), .vlpred(vlpred), .vrpred(vrpred),
        .hupred(hupred), .hdpred(hdpred), .ddlpred(ddlpred), .ddrpred(ddrpred),
        .busy(busy), .done(done), .best_mode(best_mode), .best_sad(best_sad)
    );

    intra4x4_sad_decider #(.MODE_MASK(8'h00), .SADW(12)) u_dut_m0 (
        .clk(clk), .reset(reset), .start(start), .orig(orig),
        .vpred(vpred), .hpred(hpred), .vlpred(vlpred), .vrpred(vrpred),
        .hupred(hupred), .hdpred(hdpred), .ddlpred(ddlpred), .ddrpred(ddrpred),
        .busy(busy_m), .done(done_m), .best_mode(best_mode_m), .best_sad(best_sad_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic set_in(input logic [7:0] o, v, h, ddl, ddr, vr, hd, vl, hu);
        orig = {16{o}};   vpred = {16{v}};    hpred = {16{h}};
        ddlpred = {16{ddl}}; ddrpred = {16{ddr}}; vrpred = {16{vr}};
        hdpred = {16{hd}}; vlpred = {16{vl}}; hupred = {16{hu}};
    endtask

    // Pulses start, waits (bounded) for done and checks latency and both instances' results.
    task automatic run_job(input string tag, input logic [3:0] exp_mode, input logic [11:0] exp_sad);
        int n;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && n < 60) begin
            @(negedge clk); n++;
        end
        check({tag, "_latency"}, n, 34);
        check({tag, "_mode"}, 32'(best_mode), 32'(exp_mode));
        check({tag, "_sad"}, 32'(best_sad), 32'(exp_sad));
        check({tag, "_m0_done"}, 32'(done_m), 32'd1);
        check({tag, "_m0_mode"}, 32'(best_mode_m), 32'hF);
        check({tag, "_m0_sad"}, 32'(best_sad_m), 32'hFFF);
        $display("job %s: cycles=%0d mode=%0d sad=%0d", tag, n, best_mode, best_sad);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, dones;
        set_in(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mode", 32'(best_mode), 32'hF);
        check("rst_sad", 32'(best_sad), 32'hFFF);

        set_in(8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_job("v_exact", 4'd0, 12'd0);

        set_in(8'hFF, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00);
        run_job("ddr_best", 4'd4, 12'd16);

        set_in(8'h10, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00);
        run_job("tie_h_vl", 4'd1, 12'd16);

        set_in(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_job("worst", 4'd0, 12'd4080);

        // Pixel-position test: V off by 3 at pixel 15, H off by 2 at pixel 5.
        set_in(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 16; k++) orig[8*k +: 8] = 8'(k * 16);
        vpred = orig; hpred = orig;
        vpred[127:120] = 8'hF3;
        hpred[47:40]   = 8'h52;
        run_job("pixel_pos", 4'd1, 12'd2);

        // Snapshot isolation: change inputs and re-pulse start mid-run.
        set_in(8'hFF, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        set_in(8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 6;
        while (!done && n < 60) begin
            @(negedge clk); n++;
        end
        check("snap_latency", n, 34);
        check("snap_mode", 32'(best_mode), 32'd4);
        check("snap_sad", 32'(best_sad), 32'd16);
        $display("job snapshot: cycles=%0d mode=%0d sad=%0d", n, best_mode, best_sad);
        // Start in the cycle right after done must be accepted.
        @(negedge clk); start = 1'b1;
        dones = 0;
        @(negedge clk); start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk); n++;
        end
        check("b2b_latency", n, 34);
        check("b2b_mode", 32'(best_mode), 32'd0);
        check("b2b_sad", 32'(best_sad), 32'd0);
        $display("job back_to_back: cycles=%0d mode=%0d sad=%0d", n, best_mode, best_sad);
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("snap_extra_done", dones, 0);

        // Reset in the middle of CALC aborts the run.
        set_in(8'h10, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mode", 32'(best_mode), 32'hF);
        check("abort_sad", 32'(best_sad), 32'hFFF);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || done_m) dones++;
        end
        check("abort_no_done", dones, 0);
        $display("job abort: dones_after_reset=%0d", dones);

        run_job("after_abort", 4'd1, 12'd16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
